digit_set_editor: RTL and testbench
===================================

Name: digit_set_editor

Overview:
- Parametrised successor of the stopwatch's digit-setting logic: an N-digit, per-digit-base value editor with cursor, blink and commit handshake.
- Captures the running value on edit entry and moves a cursor across digits with left/right.
- Increments or decrements the selected digit modulo its own base, blanks the selected digit at a blink rate, and emits a one-cycle commit of the edited value on exit.
- Sits between the debounced button front end and the time counters/display mux.

Parameters:
- NUM_DIGITS, 4, number of digits edited (1..8).
- DIGIT_BITS, 4, bits per digit.
- DIGIT_BASES, 32'h06_0A_06_0A, packed 8-bit base per digit, digit 0 in bits [7:0]. Each base must be in 2..2^DIGIT_BITS.
- BLINK_HALF, 5_000_000, clk cycles per blink half-period (10 Hz at 100 MHz).
- WRAP, 1: 1 means up/down wrap modulo base; 0 means saturate at 0 and base-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- edit  in  1  level; high requests edit mode
- cancel  in  1  level; abort the edit without committing
- btn_up  in  1  debounced level; acted on at its rising edge
- btn_down  in  1  debounced level; acted on at its rising edge
- btn_left  in  1  debounced level; acted on at its rising edge
- btn_right  in  1  debounced level; acted on at its rising edge
- load_value  in  NUM_DIGITS*DIGIT_BITS  current counter value, digit 0 in the LSBs
- value  out  NUM_DIGITS*DIGIT_BITS  working value being edited
- blank  out  NUM_DIGITS  1 = digit dark (display mux applies anode polarity)
- cursor  out  clog2(NUM_DIGITS) (min 1)  index of the selected digit
- editing  out  1  high in EDIT
- commit_valid  out  1  one-cycle pulse; value is valid for commit

Behaviour:
- Reset values: state IDLE, value 0, cursor NUM_DIGITS-1, blank 0, editing 0, commit_valid 0, blink counter 0, blink phase 0, all edge-detect registers 0.
- Edge detect: each button is registered once; pulse = level & ~previous. Only pulses act. Held buttons never auto-repeat.
- States: IDLE, EDIT, COMMIT.
- IDLE:
  - value tracks load_value each cycle.
  - When edit=1 and cancel=0: capture load_value, clamping any digit >= base to base-1. Set cursor=NUM_DIGITS-1, clear blink counter/phase, go to EDIT.
- EDIT, priority order:
  - cancel=1: go to IDLE, no commit_valid.
  - Otherwise edit=0: go to COMMIT.
  - Otherwise apply button pulses.
- Cursor moves:
  - left pulse: cursor+1, saturating at NUM_DIGITS-1.
  - right pulse: cursor-1, saturating at 0.
  - Simultaneous left and right: no move.
  - Any actual cursor change resets the blink counter and sets phase 0, so the new digit shows lit immediately.
- Digit edits:
  - up pulse: selected digit d becomes (d==base-1) ? (WRAP ? 0 : d) : d+1.
  - down pulse: d becomes (d==0) ? (WRAP ? base-1 : 0) : d-1.
  - Simultaneous up and down: no change.
  - A digit edit and a cursor move in the same cycle: the digit edit applies to the pre-move cursor.
  - Other digits are never modified.
- COMMIT: commit_valid=1 for exactly one cycle with value held, then go to IDLE. An edit=1 seen in COMMIT is ignored until IDLE, so re-entry costs at least one IDLE cycle.
- Blink:
  - Active only in EDIT. The counter counts 0..BLINK_HALF-1; at terminal count the phase toggles.
  - blank[cursor] = phase; all other blank bits 0.
  - In IDLE and COMMIT, blank=0 and the counter is held at 0.
- editing = (state==EDIT).
- Latency: a button pulse is reflected in value/cursor 2 cycles after the level rises (one cycle sync, one cycle update).
- Reset asserted mid-edit: immediate return to reset values, no commit_valid.

Test Plan:
- Reset, load_value=16'h5959, edit=1 -> EDIT next cycle, value=16'h5959, cursor=3, blank[3] toggles every BLINK_HALF cycles, blank[2:0]=0.
- In EDIT, cursor=0: up pulse on value ...9 -> digit0=0 (WRAP=1); with WRAP=0 digit0 stays 9. Down pulse on digit1=0 -> 5.
- right ×5 from cursor 3 -> cursor 0 and stays 0. left ×5 -> cursor 3. left and right high in the same cycle -> cursor unchanged. blank phase restarts at 0 after each actual move.
- Edit 16'h1234 to 16'h1235, then drop edit -> single commit_valid pulse with value=16'h1235, then IDLE with value tracking load_value. Repeat with cancel=1 -> no commit_valid.
- load_value=16'hF9F9 on entry -> value=16'h5959 (clamped). up and down together on a digit -> no change.
- Holding btn_up for 100 cycles -> exactly one increment. Assert rst mid-EDIT -> all outputs at reset values next cycle, no commit_valid.

Source files
------------

// File: rtl/digit_set_editor_if.sv
// Handshake bundle between the button front end / counters and the digit editor.
// master drives buttons and the live counter value; slave is the editor itself.
interface digit_set_editor_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_BITS = 4
);
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                             edit;
  logic                             cancel;
  logic                             btn_up;
  logic                             btn_down;
  logic                             btn_left;
  logic                             btn_right;
  logic [NUM_DIGITS*DIGIT_BITS-1:0] load_value;
  logic [NUM_DIGITS*DIGIT_BITS-1:0] value;
  logic [NUM_DIGITS-1:0]            blank;
  logic [CW-1:0]                    cursor;
  logic                             editing;
  logic                             commit_valid;

  modport master (
    output edit, cancel, btn_up, btn_down, btn_left, btn_right, load_value,
    input  value, blank, cursor, editing, commit_valid
  );

  modport slave (
    input  edit, cancel, btn_up, btn_down, btn_left, btn_right, load_value,
    output value, blank, cursor, editing, commit_valid
  );
endinterface

// File: rtl/digit_set_editor.sv
// N-digit per-base value editor: captures a running value, edits one digit at a
// time under a blinking cursor and emits a one-cycle commit when edit drops.
module digit_set_lane #(
  parameter int DIGIT_BITS = 4,
  parameter int BASE       = 10,
  parameter int WRAP       = 1
) (
  input  logic [DIGIT_BITS-1:0] i_d,
  input  logic [DIGIT_BITS-1:0] i_load,
  input  logic                  i_sel,
  input  logic                  i_up,
  input  logic                  i_dn,
  output logic [DIGIT_BITS-1:0] o_clamped,
  output logic [DIGIT_BITS-1:0] o_next
);
  localparam logic [DIGIT_BITS-1:0] TOP = DIGIT_BITS'(BASE - 1);

  assign o_clamped = (i_load > TOP) ? TOP : i_load;

  always_comb begin
    o_next = i_d;
    if (i_sel && i_up && !i_dn)
      o_next = (i_d == TOP) ? ((WRAP != 0) ? '0 : i_d) : i_d + 1'b1;
    else if (i_sel && i_dn && !i_up)
      o_next = (i_d == '0) ? ((WRAP != 0) ? TOP : '0) : i_d - 1'b1;
  end
endmodule

module digit_set_editor #(
  parameter int          NUM_DIGITS  = 4,
  parameter int          DIGIT_BITS  = 4,
  parameter logic [63:0] DIGIT_BASES = 64'h06_0A_06_0A,
  parameter int          BLINK_HALF  = 5_000_000,
  parameter int          WRAP        = 1
) (
  input logic                clk,
  input logic                rst,
  digit_set_editor_if.slave  bus
);
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CUR_MAX = CW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BL_TC   = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_t;

  state_t r_state, w_next;

  logic [NUM_DIGITS-1:0][DIGIT_BITS-1:0] r_value, w_clamped, w_edited;
  logic [CW-1:0] r_cursor, w_cur_nxt;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic          w_cur_mv;
  // button order {left, right, down, up}
  logic [3:0]    w_btn, r_btn_s, r_btn_q, w_pls;

  assign w_btn = {bus.btn_left, bus.btn_right, bus.btn_down, bus.btn_up};
  assign w_pls = r_btn_s & ~r_btn_q;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
    digit_set_lane #(
      .DIGIT_BITS (DIGIT_BITS),
      .BASE       (int'(DIGIT_BASES[8*i +: 8])),
      .WRAP       (WRAP)
    ) u_lane (
      .i_d       (r_value[i]),
      .i_load    (bus.load_value[i*DIGIT_BITS +: DIGIT_BITS]),
      .i_sel     (r_cursor == CW'(i)),
      .i_up      (w_pls[0]),
      .i_dn      (w_pls[1]),
      .o_clamped (w_clamped[i]),
      .o_next    (w_edited[i])
    );
  end

  always_comb begin
    w_cur_nxt = r_cursor;
    if (w_pls[3] && !w_pls[2] && r_cursor != CUR_MAX) w_cur_nxt = r_cursor + 1'b1;
    if (w_pls[2] && !w_pls[3] && r_cursor != '0)      w_cur_nxt = r_cursor - 1'b1;
    w_cur_mv = (w_cur_nxt != r_cursor);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.edit && !bus.cancel) w_next = S_EDIT;
      S_EDIT:   if (bus.cancel) w_next = S_IDLE;
                else if (!bus.edit) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value     <= '0;
      r_cursor    <= CUR_MAX;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_btn_s     <= '0;
      r_btn_q     <= '0;
    end else begin
      r_btn_s     <= w_btn;
      r_btn_q     <= r_btn_s;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_next == S_EDIT) begin
            r_value  <= w_clamped;
            r_cursor <= CUR_MAX;
          end else begin
            r_value  <= bus.load_value;
          end
        end
        S_EDIT: begin
          if (w_next == S_EDIT) begin
            r_value  <= w_edited;
            r_cursor <= w_cur_nxt;
            // a real cursor move restarts blink so the new digit shows lit
            if (!w_cur_mv) begin
              if (r_blink_cnt == BL_TC) begin
                r_phase <= ~r_phase;
              end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
                r_phase     <= r_phase;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.value        = r_value;
  assign bus.cursor       = r_cursor;
  assign bus.editing      = (r_state == S_EDIT);
  assign bus.commit_valid = (r_state == S_COMMIT);

  always_comb begin
    bus.blank = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      bus.blank[i] = (r_state == S_EDIT) && r_phase && (r_cursor == CW'(i));
  end
endmodule

// File: tb/tb_digit_set_editor.sv
// Drives one wrapping and one saturating editor with identical stimulus and
// compares both against a digit-array reference model every cycle.
module tb_digit_set_editor;
  localparam int          N     = 4;
  localparam int          DB    = 4;
  localparam int          BH    = 4;
  localparam logic [63:0] BASES = 64'h06_0A_06_0A;

  logic clk = 1'b0;
  logic rst;
  logic edit, cancel, up, dn, lf, rt;
  logic [N*DB-1:0] load;

  always #5 clk = ~clk;

  digit_set_editor_if #(.NUM_DIGITS(N), .DIGIT_BITS(DB)) bif1 ();
  digit_set_editor_if #(.NUM_DIGITS(N), .DIGIT_BITS(DB)) bif0 ();

  assign bif1.edit = edit;   assign bif0.edit = edit;
  assign bif1.cancel = cancel; assign bif0.cancel = cancel;
  assign bif1.btn_up = up;   assign bif0.btn_up = up;
  assign bif1.btn_down = dn; assign bif0.btn_down = dn;
  assign bif1.btn_left = lf; assign bif0.btn_left = lf;
  assign bif1.btn_right = rt; assign bif0.btn_right = rt;
  assign bif1.load_value = load; assign bif0.load_value = load;

  digit_set_editor #(.NUM_DIGITS(N), .DIGIT_BITS(DB), .DIGIT_BASES(BASES),
                     .BLINK_HALF(BH), .WRAP(1)) dut1 (.clk(clk), .rst(rst), .bus(bif1));
  digit_set_editor #(.NUM_DIGITS(N), .DIGIT_BITS(DB), .DIGIT_BASES(BASES),
                     .BLINK_HALF(BH), .WRAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bif0));

  // reference model: digits as integers, mode 0 idle / 1 edit / 2 commit,
  // m_age = EDIT cycles since entry or last cursor move
  int mv1 [N];
  int mv0 [N];
  int m_cur, m_mode, m_age;
  logic [3:0] m_s1, m_s2;
  int errors = 0;
  int checks = 0;

  function automatic int base_of(input int i);
    logic [63:0] b;
    b = BASES >> (8 * i);
    return int'(b[7:0]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mv1[i] = 0; mv0[i] = 0; end
    m_cur = N - 1; m_mode = 0; m_age = 0; m_s1 = '0; m_s2 = '0;
  endtask

  task automatic model_step();
    logic [3:0] p;
    int b, c, nc, d;
    p = m_s1 & ~m_s2;
    case (m_mode)
      0: begin
        for (int i = 0; i < N; i++) begin
          d = int'(load[DB*i +: DB]);
          if (edit && !cancel && d > base_of(i) - 1) d = base_of(i) - 1;
          mv1[i] = d; mv0[i] = d;
        end
        if (edit && !cancel) begin m_cur = N - 1; m_age = 0; m_mode = 1; end
      end
      1: begin
        if (cancel) m_mode = 0;
        else if (!edit) m_mode = 2;
        else begin
          c = m_cur; b = base_of(c);
          if (p[0] && !p[1]) begin
            mv1[c] = (mv1[c] + 1) % b;
            mv0[c] = (mv0[c] + 1 > b - 1) ? b - 1 : mv0[c] + 1;
          end else if (p[1] && !p[0]) begin
            mv1[c] = (mv1[c] + b - 1) % b;
            mv0[c] = (mv0[c] == 0) ? 0 : mv0[c] - 1;
          end
          nc = m_cur + ((p[3] && !p[2]) ? 1 : 0) - ((p[2] && !p[3]) ? 1 : 0);
          if (nc < 0) nc = 0;
          if (nc > N - 1) nc = N - 1;
          if (nc != m_cur) m_age = 0; else m_age++;
          m_cur = nc;
        end
      end
      default: m_mode = 0;
    endcase
    m_s2 = m_s1;
    m_s1 = {lf, rt, dn, up};
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N*DB-1:0] e1, e0;
    logic [N-1:0]    eb;
    for (int i = 0; i < N; i++) begin
      e1[DB*i +: DB] = DB'(mv1[i]);
      e0[DB*i +: DB] = DB'(mv0[i]);
    end
    eb = '0;
    if (m_mode == 1 && ((m_age / BH) % 2) == 1) eb[m_cur] = 1'b1;
    check({tag, ".value_wrap"}, 32'(bif1.value), 32'(e1));
    check({tag, ".value_sat"},  32'(bif0.value), 32'(e0));
    check({tag, ".cursor"},     32'(bif1.cursor), 32'(m_cur));
    check({tag, ".editing"},    32'(bif1.editing), 32'(m_mode == 1));
    check({tag, ".commit"},     32'(bif1.commit_valid), 32'(m_mode == 2));
    check({tag, ".blank"},      32'(bif1.blank), 32'(eb));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic press(input logic [3:0] m, input string tag);
    {lf, rt, dn, up} = m;
    tick(tag);
    tick(tag);
    {lf, rt, dn, up} = 4'b0000;
    tick(tag);
  endtask

  initial begin
    rst = 1'b1; edit = 0; cancel = 0; {lf, rt, dn, up} = 4'b0000; load = '0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    load = 16'h5959; edit = 1'b1;
    tick("enter");
    repeat (2 * BH + 2) tick("blink");

    repeat (5) press(4'b0100, "right");
    press(4'b0001, "up_d0");
    press(4'b1000, "left1");
    repeat (6) press(4'b0010, "down_d1");
    repeat (5) press(4'b1000, "left");
    press(4'b1100, "left_right");
    repeat (BH + 1) tick("blink2");

    edit = 1'b0;
    tick("commit"); tick("post_commit");
    load = 16'h1234;
    tick("idle_track"); tick("idle_track");
    edit = 1'b1;
    tick("enter1234");
    repeat (3) press(4'b0100, "r1234");
    press(4'b0001, "inc1234");
    edit = 1'b0;
    tick("commit1235"); tick("idle1235");
    load = 16'h4321;
    tick("idle_track2");

    edit = 1'b1;
    tick("enter_c");
    press(4'b0001, "up_c");
    cancel = 1'b1;
    tick("cancel");
    cancel = 1'b0; edit = 1'b0;
    tick("after_cancel"); tick("after_cancel");

    load = 16'hF9F9; edit = 1'b1;
    tick("clamp");
    press(4'b0011, "updown");

    up = 1'b1;
    repeat (100) tick("hold_up");
    up = 1'b0;
    tick("hold_rel");

    repeat (400) begin
      edit   = ($urandom_range(0, 19) != 0);
      cancel = ($urandom_range(0, 49) == 0);
      load   = 16'($urandom);
      if ($urandom_range(0, 2) == 0) {lf, rt, dn, up} = 4'($urandom_range(0, 15));
      tick("rand");
    end

    edit = 0; cancel = 0; {lf, rt, dn, up} = 4'b0000;
    repeat (3) tick("settle");
    load = 16'h1234; edit = 1'b1;
    tick("enter_rst");
    press(4'b0001, "up_rst");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk); #1;
    check_all("rst_held");
    rst = 1'b0; edit = 1'b0;
    tick("post_rst"); tick("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
